pc_seq_ctrl: RTL and testbench

- Control sequencer for the next-PC unit; drives the 3-bit next-PC select code and the PC register write-enable each cycle.
- Owns the minimal coprocessor-0 state: EPC, status (IE, EXL) and cause code.
- Arbitrates between sequential flow, branches, jumps, exceptions, interrupts and eret, and inserts a one-cycle redirect state on exception or interrupt entry.
- Sits between the decode/control unit and the next-PC unit / PC register.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_seq_ctrl_cp0_regs.sv | 69 ++++++
 rtl/pc_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: next-PC select codes, cause codes
// and the sequencer state type.
package pc_seq_pkg;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b100;
  localparam logic [2:0] NPC_EXC = 3'b101;
  localparam logic [2:0] NPC_EPC = 3'b110;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } state_e;

endpackage

// File: rtl/pc_seq_ctrl_cp0_regs.sv
// Minimal coprocessor-0 state (EPC, SR.IE/EXL, Cause code) with its
// write-priority logic: trap entry beats mtc0, which beats eret.
module cp0_regs
  import pc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enter,
  input  logic [4:0]  enter_code,
  input  logic [29:0] pc,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic        cp0_sel,
  input  logic [31:0] cp0_wdata,
  output logic [29:0] epc,
  output logic        ie,
  output logic        exl,
  output logic [4:0]  exc_code
);

  logic [29:0] epc_q, epc_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [4:0]  exc_code_q, exc_code_d;

  always_comb begin
    epc_d      = epc_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    exc_code_d = exc_code_q;
    if (enter) begin
      epc_d      = pc;
      exl_d      = 1'b1;
      exc_code_d = enter_code;
    end else begin
      if (eret) begin
        exl_d = 1'b0;
      end
      if (mtc0_we) begin
        if (cp0_sel) begin
          epc_d = cp0_wdata[31:2];
        end else begin
          ie_d  = cp0_wdata[0];
          exl_d = cp0_wdata[1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q      <= '0;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      exc_code_q <= EXC_INT;
    end else begin
      epc_q      <= epc_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      exc_code_q <= exc_code_d;
    end
  end

  assign epc      = epc_q;
  assign ie       = ie_q;
  assign exl      = exl_q;
  assign exc_code = exc_code_q;

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC control sequencer: arbitrates sequential flow, branches, jumps,
// eret and trap entry, and inserts one REDIR cycle to fetch the vector.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = 32'h0000_4180,
  parameter int          IRQ_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [29:0]      pc,
  input  logic             stall,
  input  logic             is_beq,
  input  logic             is_j,
  input  logic             is_jr,
  input  logic             is_eret,
  input  logic             exc_req,
  input  logic [4:0]       exc_code_in,
  input  logic [IRQ_W-1:0] irq,
  input  logic             cp0_we,
  input  logic             cp0_sel,
  input  logic [31:0]      cp0_wdata,
  output logic [2:0]       npc_sel,
  output logic             pc_we,
  output logic             squash,
  output logic [29:0]      epc,
  output logic             ie,
  output logic             exl,
  output logic [4:0]       exc_code
);

  state_e     state_q, state_d;
  logic       take_irq;
  logic       enter;
  logic [4:0] enter_code;
  logic       eret_fire;
  logic       mtc0_fire;

  // Interrupts only enter from RUN when enabled and not already in a handler.
  assign take_irq = (|irq) & ie & ~exl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!stall && (exc_req || take_irq)) state_d = REDIR;
      REDIR:   if (!stall) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced idle while reset is held, even mid-REDIR.
  always_comb begin
    npc_sel    = NPC_SEQ;
    pc_we      = 1'b0;
    squash     = 1'b0;
    enter      = 1'b0;
    enter_code = EXC_INT;
    eret_fire  = 1'b0;
    mtc0_fire  = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (stall) begin
            squash = 1'b1;
          end else if (exc_req) begin
            squash     = 1'b1;
            enter      = 1'b1;
            enter_code = exc_code_in;
          end else if (take_irq) begin
            squash = 1'b1;
            enter  = 1'b1;
          end else begin
            pc_we     = 1'b1;
            mtc0_fire = cp0_we;
            if (is_eret) begin
              npc_sel   = NPC_EPC;
              eret_fire = 1'b1;
            end else if (is_jr) begin
              npc_sel = NPC_JR;
            end else if (is_j) begin
              npc_sel = NPC_J;
            end else if (is_beq) begin
              npc_sel = NPC_BEQ;
            end
          end
        end
        REDIR: begin
          npc_sel = NPC_EXC;
          squash  = 1'b1;
          pc_we   = ~stall;
        end
        default: ;
      endcase
    end
  end

  cp0_regs u_cp0 (
    .clk        (clk),
    .rst        (rst),
    .enter      (enter),
    .enter_code (enter_code),
    .pc         (pc),
    .eret       (eret_fire),
    .mtc0_we    (mtc0_fire),
    .cp0_sel    (cp0_sel),
    .cp0_wdata  (cp0_wdata),
    .epc        (epc),
    .ie         (ie),
    .exl        (exl),
    .exc_code   (exc_code)
  );

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural CP0/sequencer model.
module tb_pc_seq_ctrl;

  localparam int IRQ_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [29:0]      pc;
  logic             stall;
  logic             is_beq, is_j, is_jr, is_eret;
  logic             exc_req;
  logic [4:0]       exc_code_in;
  logic [IRQ_W-1:0] irq;
  logic             cp0_we;
  logic             cp0_sel;
  logic [31:0]      cp0_wdata;
  logic [2:0]       npc_sel;
  logic             pc_we;
  logic             squash;
  logic [29:0]      epc;
  logic             ie;
  logic             exl;
  logic [4:0]       exc_code;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: architectural CP0 state plus "vector fetch pending" flag.
  bit          mVecPending;
  logic [29:0] mEpc;
  bit          mIe;
  bit          mExl;
  logic [4:0]  mCode;

  pc_seq_ctrl #(.EXC_VEC(32'h0000_4180), .IRQ_W(IRQ_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .stall       (stall),
    .is_beq      (is_beq),
    .is_j        (is_j),
    .is_jr       (is_jr),
    .is_eret     (is_eret),
    .exc_req     (exc_req),
    .exc_code_in (exc_code_in),
    .irq         (irq),
    .cp0_we      (cp0_we),
    .cp0_sel     (cp0_sel),
    .cp0_wdata   (cp0_wdata),
    .npc_sel     (npc_sel),
    .pc_we       (pc_we),
    .squash      (squash),
    .epc         (epc),
    .ie          (ie),
    .exl         (exl),
    .exc_code    (exc_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mVecPending = 1'b0;
    mEpc        = '0;
    mIe         = 1'b0;
    mExl        = 1'b0;
    mCode       = 5'd0;
  endtask

  // dec = {eret, jr, j, beq}
  task automatic applyStimulus(input logic [29:0] p, input logic st, input logic ex,
                               input logic [4:0] code, input logic [IRQ_W-1:0] ir,
                               input logic [3:0] dec, input logic we, input logic sel,
                               input logic [31:0] wd);
    pc          = p;
    stall       = st;
    exc_req     = ex;
    exc_code_in = code;
    irq         = ir;
    is_eret     = dec[3];
    is_jr       = dec[2];
    is_j        = dec[1];
    is_beq      = dec[0];
    cp0_we      = we;
    cp0_sel     = sel;
    cp0_wdata   = wd;
  endtask

  // Predict this cycle's outputs from the architectural rules, compare,
  // then advance the model to what the coming clock edge should produce.
  task automatic modelCycle();
    logic [2:0] eNpc;
    bit         eWe, eSq, trap, wasVec;
    logic [4:0] trapCode;
    eNpc = 3'b000; eWe = 1'b0; eSq = 1'b0; trap = 1'b0; trapCode = 5'd0;
    wasVec = mVecPending;

    checkOutput("epc", {2'b00, epc}, {2'b00, mEpc});
    checkOutput("ie", {31'd0, ie}, {31'd0, mIe});
    checkOutput("exl", {31'd0, exl}, {31'd0, mExl});
    checkOutput("exc_code", {27'd0, exc_code}, {27'd0, mCode});

    if (wasVec) begin
      eNpc = 3'b101;
      eSq  = 1'b1;
      eWe  = !stall;
      if (!stall) mVecPending = 1'b0;
    end else if (stall) begin
      eSq = 1'b1;
    end else begin
      if (exc_req) begin
        trap = 1'b1; trapCode = exc_code_in;
      end else if ((irq != 0) && mIe && !mExl) begin
        trap = 1'b1; trapCode = 5'd0;
      end
      if (trap) begin
        eSq = 1'b1;
      end else begin
        eWe = 1'b1;
        if (is_eret)     eNpc = 3'b110;
        else if (is_jr)  eNpc = 3'b100;
        else if (is_j)   eNpc = 3'b010;
        else if (is_beq) eNpc = 3'b001;
      end
    end

    checkOutput("npc_sel", {29'd0, npc_sel}, {29'd0, eNpc});
    checkOutput("pc_we", {31'd0, pc_we}, {31'd0, eWe});
    checkOutput("squash", {31'd0, squash}, {31'd0, eSq});

    if (trap) begin
      mEpc = pc; mExl = 1'b1; mCode = trapCode; mVecPending = 1'b1;
    end else if (!wasVec && !stall) begin
      if (is_eret) mExl = 1'b0;
      if (cp0_we) begin
        if (cp0_sel) mEpc = cp0_wdata[31:2];
        else begin mIe = cp0_wdata[0]; mExl = cp0_wdata[1]; end
      end
    end
  endtask

  task automatic runCycle(input logic [29:0] p, input logic st, input logic ex,
                          input logic [4:0] code, input logic [IRQ_W-1:0] ir,
                          input logic [3:0] dec, input logic we, input logic sel,
                          input logic [31:0] wd);
    @(negedge clk);
    applyStimulus(p, st, ex, code, ir, dec, we, sel, wd);
    #1;
    modelCycle();
  endtask

  initial begin
    logic [3:0] dec;
    logic       rwe;
    rst = 1'b1;
    applyStimulus(30'h0, 1'b0, 1'b0, 5'd0, '0, 4'b0, 1'b0, 1'b0, 32'h0);
    modelReset();
    #2;
    checkOutput("rst_npc_sel", {29'd0, npc_sel}, 32'd0);
    checkOutput("rst_pc_we", {31'd0, pc_we}, 32'd0);
    checkOutput("rst_squash", {31'd0, squash}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) runCycle(30'hC00, 0, 0, 5'd0, '0, 4'b0000, 0, 0, 0);

    // syscall entry and vector fetch
    runCycle(30'hC04, 0, 1, 5'd8, '0, 4'b0000, 0, 0, 0);
    runCycle(30'hC05, 0, 0, 5'd0, '0, 4'b0000, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("sys_epc", {2'b00, epc}, 32'hC04);
    checkOutput("sys_exl", {31'd0, exl}, 32'd1);
    checkOutput("sys_code", {27'd0, exc_code}, 32'd8);

    // eret, then masked interrupt, then enable via mtc0
    runCycle(30'h1060, 0, 0, 5'd0, '0, 4'b1000, 0, 0, 0);
    runCycle(30'hC04, 0, 0, 5'd0, 6'b000001, 4'b0000, 0, 0, 0);
    runCycle(30'hC05, 0, 0, 5'd0, 6'b000001, 4'b0000, 0, 0, 0);
    runCycle(30'hC10, 0, 0, 5'd0, 6'b000001, 4'b0000, 1, 0, 32'h1);
    runCycle(30'hC11, 0, 0, 5'd0, 6'b000001, 4'b0000, 0, 0, 0);
    runCycle(30'hC12, 0, 0, 5'd0, 6'b000001, 4'b0000, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("irq_epc", {2'b00, epc}, 32'hC11);
    checkOutput("irq_code", {27'd0, exc_code}, 32'd0);
    runCycle(30'h1060, 0, 0, 5'd0, 6'b000001, 4'b0000, 0, 0, 0);
    runCycle(30'h1061, 0, 0, 5'd0, 6'b000001, 4'b1000, 0, 0, 0);
    runCycle(30'hC11, 0, 0, 5'd0, 6'b000001, 4'b0000, 0, 0, 0);
    runCycle(30'hC12, 0, 0, 5'd0, 6'b000001, 4'b0000, 0, 0, 0);
    runCycle(30'h1060, 0, 0, 5'd0, '0, 4'b0000, 1, 0, 32'h0);

    // stall precedence over exception, including stall inside REDIR
    runCycle(30'hC30, 1, 1, 5'd10, '0, 4'b0000, 0, 0, 0);
    runCycle(30'hC30, 1, 1, 5'd10, '0, 4'b0000, 0, 0, 0);
    runCycle(30'hC30, 0, 1, 5'd10, '0, 4'b0000, 0, 0, 0);
    runCycle(30'hC31, 1, 0, 5'd0, '0, 4'b0000, 0, 0, 0);
    runCycle(30'hC31, 0, 0, 5'd0, '0, 4'b0000, 0, 0, 0);
    runCycle(30'h1060, 0, 0, 5'd0, '0, 4'b0000, 1, 1, 32'h1234_5678);
    runCycle(30'h1061, 0, 0, 5'd0, '0, 4'b0101, 0, 0, 0);
    runCycle(30'h1062, 0, 0, 5'd0, '0, 4'b0011, 0, 0, 0);

    // reset asserted while in REDIR
    runCycle(30'hC40, 0, 1, 5'd12, '0, 4'b0000, 0, 0, 0);
    runCycle(30'hC41, 0, 0, 5'd0, '0, 4'b0000, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstredir_npc_sel", {29'd0, npc_sel}, 32'd0);
    checkOutput("rstredir_pc_we", {31'd0, pc_we}, 32'd0);
    checkOutput("rstredir_epc", {2'b00, epc}, 32'd0);
    checkOutput("rstredir_exl", {31'd0, exl}, 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) runCycle(30'hD00, 0, 0, 5'd0, '0, 4'b0000, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      dec = 4'b0000;
      case ($urandom_range(0, 9))
        0:       dec = 4'b0001;
        1:       dec = 4'b0010;
        2:       dec = 4'b0100;
        3:       dec = 4'b1000;
        4:       dec = 4'($urandom);
        default: dec = 4'b0000;
      endcase
      rwe = (dec == 4'b0000) && ($urandom_range(0, 5) == 0);
      runCycle(30'($urandom),
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 9) == 0,
               5'($urandom),
               ($urandom_range(0, 3) == 0) ? IRQ_W'($urandom) : '0,
               dec, rwe, 1'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
